pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Central hazard and redirect controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). It combines the EX-stage branch redirect, the ID-stage load-use hazard and the IF/MEM bus-busy signals into per-stage stall and flush controls and a PC-load command. It holds a redirect target when the fetch port is busy, so that an in-flight fetch completes before the PC changes. It also keeps saturating stall and flush counters for performance debug.

Parameters:
PC_ADDR, 32'h8000_0000, reset PC; value of pc_target when no redirect is active.
ADDR_WIDTH, 32, width of PC and target addresses.
CNT_WIDTH, 32, width of the performance counters.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
redirect_req  in  1  EX branch/jump taken; the current PC path is wrong.
redirect_pc  in  ADDR_WIDTH  target address; valid when redirect_req=1.
load_use  in  1  ID instruction needs a result from the load currently in EX.
if_busy  in  1  fetch bus transaction outstanding (ack not yet returned).
mem_busy  in  1  MEM-stage data bus transaction outstanding.
cnt_clear  in  1  synchronous clear of both counters.
stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold the corresponding stage register.
flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  insert a bubble into that pipeline register.
pc_load  out  1  IF loads pc_target this cycle.
pc_target  out  ADDR_WIDTH  redirect address.
redir_pending  out  1  state == S_PEND.
stall_cnt  out  CNT_WIDTH  cycles with stall_if=1.
flush_cnt  out  CNT_WIDTH  redirects accepted.

Behaviour:
- Reset values:
  - state = S_RUN; pend_pc = PC_ADDR; both counters = 0.
  - All stall, flush and pc_load outputs = 0; pc_target = PC_ADDR.
- Control outputs are combinational from state, inputs and pend_pc. State, pend_pc and the counters are registered.
- The priority order below is evaluated every cycle; the first matching row wins.
- P1, mem_busy=1:
  - stall_if = stall_id = stall_ex = stall_mem = 1.
  - flush_ex_mem = 0; a bubble goes into MEM/WB via the WB-stage valid (owned by the MEM stage).
  - redirect_req and load_use are ignored. EX is frozen, so redirect_req stays asserted until the stall releases.
  - State is unchanged.
- P2, S_RUN with redirect_req=1:
  - flush_if_id = flush_id_ex = 1; stalls = 0.
  - If if_busy=0: pc_load = 1, pc_target = redirect_pc, stay in S_RUN. Redirect latency is 0 cycles.
  - If if_busy=1: pc_load = 0, pend_pc <= redirect_pc, go to S_PEND.
  - flush_cnt increments in both cases.
- P3, S_PEND:
  - flush_if_id = 1 every cycle, which discards the fetch returning on the old path.
  - stall_if = if_busy.
  - When if_busy=0: pc_load = 1, pc_target = pend_pc, go to S_RUN.
  - If redirect_req=1 arrives while in S_PEND: pend_pc <= redirect_pc (newest wins), flush_id_ex = 1, flush_cnt increments.
  - If that redirect arrives in the same cycle that if_busy=0: pc_target = redirect_pc directly.
- P4, S_RUN with load_use=1 (no redirect):
  - stall_if = stall_id = 1, flush_id_ex = 1.
  - Exactly one bubble per assertion cycle.
- P5, S_RUN with if_busy=1 only:
  - stall_if = 1, flush_if_id = 1, which feeds ID a bubble while fetch waits.
- Otherwise all outputs = 0 and pc_target = PC_ADDR.
- Redirect overrides load_use, because the dependent instruction is on the squashed path.
- Counters:
  - stall_cnt increments each cycle with stall_if=1.
  - Both counters saturate at all-ones and never wrap.
  - If cnt_clear=1 and an increment happen in the same cycle, the counter is cleared to 0.
- Reset mid-operation: from S_PEND, an asserted reset returns to S_RUN immediately; the pending target is discarded (pend_pc = PC_ADDR) and pc_load stays 0.

Decomposition:
- Package pipeline_ctrl_pkg: ctrl_state_e {S_RUN, S_PEND}; a packed struct stage_ctrl_t grouping the stall and flush bits, which the pipeline top consumes.
- One sub-module, sat_counter (parameter WIDTH; inputs inc and clr), instantiated twice.

Test Plan:
- Reset: assert reset for 3 cycles, then release -> all stalls/flushes 0, pc_target=32'h8000_0000, counters 0.
- Redirect with fetch idle: redirect_req=1, redirect_pc=32'h8000_0100, if_busy=0 -> same cycle pc_load=1, pc_target=32'h8000_0100, flush_if_id=flush_id_ex=1; flush_cnt=1 on the next cycle.
- Redirect with fetch busy: redirect_pc=32'h8000_0040 with if_busy=1 for 3 cycles -> redir_pending=1 and flush_if_id=1 for 3 cycles; pc_load=1 with target 32'h8000_0040 in the cycle if_busy falls; then S_RUN.
- Simultaneous events: mem_busy=1 together with redirect_req and load_use -> all four stalls = 1, no flush, no pc_load; when mem_busy drops, the redirect is taken (P2).
- Load-use: load_use=1 for 1 cycle -> stall_if=stall_id=1, flush_id_ex=1 for exactly 1 cycle; stall_cnt=1.
- Saturation and reset: preload stall_cnt near max with a forced stall -> holds at 2^CNT_WIDTH-1; cnt_clear gives 0. Assert reset while in S_PEND -> S_RUN, no pc_load afterwards.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/redirect controller.
//   ctrl_state_e : redirect FSM states (running / redirect waiting on fetch)
//   stage_ctrl_t : per-stage stall and flush bits consumed by the pipeline top
package pipeline_ctrl_pkg;

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_PEND = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_ex_mem;
    } stage_ctrl_t;

    localparam stage_ctrl_t STAGE_CTRL_IDLE = 7'b000_0000;

    // Full-pipeline freeze used while the MEM data bus is busy; MEM/WB gets
    // its bubble through the WB valid bit, so no flush is raised here.
    function automatic stage_ctrl_t stall_all();
        stage_ctrl_t c;
        c           = STAGE_CTRL_IDLE;
        c.stall_if  = 1'b1;
        c.stall_id  = 1'b1;
        c.stall_ex  = 1'b1;
        c.stall_mem = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset : clock, asynchronous active-high reset
//   inc        : count this cycle (ignored once all-ones)
//   clr        : clear to zero; wins over inc
//   count      : current value
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Counter register: clear first, then increment only below saturation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            count_r <= {WIDTH{1'b0}};
        end else if (inc && !(&count_r)) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and redirect controller for the 5-stage pipeline.
// Merges the EX redirect, ID load-use hazard and IF/MEM bus-busy signals into
// per-stage stall/flush controls and a PC-load command. A redirect arriving
// while fetch is busy is parked in pend_pc until the in-flight fetch returns.
//   clk, reset           : clock, asynchronous active-high reset
//   redirect_req/_pc     : EX taken branch/jump and its target
//   load_use             : ID depends on the load now in EX
//   if_busy, mem_busy    : fetch / data bus transaction outstanding
//   cnt_clear            : synchronous clear of both perf counters
//   stall_*, flush_*     : stage register hold / bubble insert
//   pc_load, pc_target   : IF loads pc_target this cycle
//   redir_pending        : a redirect is parked waiting for fetch
//   stall_cnt, flush_cnt : saturating stalled-cycle and redirect counts
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 32'h8000_0000,
    parameter int                    CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect_req,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  load_use,
    input  logic                  if_busy,
    input  logic                  mem_busy,
    input  logic                  cnt_clear,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  stall_ex,
    output logic                  stall_mem,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic                  flush_ex_mem,
    output logic                  pc_load,
    output logic [ADDR_WIDTH-1:0] pc_target,
    output logic                  redir_pending,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  flush_cnt
);

    ctrl_state_e           state_r;
    ctrl_state_e           state_nxt_s;
    logic [ADDR_WIDTH-1:0] pend_pc_r;
    logic [ADDR_WIDTH-1:0] pend_pc_nxt_s;
    stage_ctrl_t           ctrl_s;
    logic                  pc_load_s;
    logic [ADDR_WIDTH-1:0] pc_target_s;
    logic                  flush_inc_s;

    // State and parked redirect target registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_RUN;
            pend_pc_r <= PC_ADDR;
        end else begin
            state_r   <= state_nxt_s;
            pend_pc_r <= pend_pc_nxt_s;
        end
    end

    // Priority resolution: MEM freeze, parked redirect, new redirect,
    // load-use, fetch wait, idle.
    always_comb begin
        ctrl_s        = STAGE_CTRL_IDLE;
        pc_load_s     = 1'b0;
        pc_target_s   = PC_ADDR;
        flush_inc_s   = 1'b0;
        state_nxt_s   = state_r;
        pend_pc_nxt_s = pend_pc_r;

        if (mem_busy) begin
            // EX is frozen, so any redirect stays asserted and is seen later.
            ctrl_s = stall_all();
        end else begin
            case (state_r)
                S_PEND: begin
                    // Keep discarding whatever the old-path fetch returns.
                    ctrl_s.flush_if_id = 1'b1;
                    ctrl_s.stall_if    = if_busy;
                    if (redirect_req) begin
                        pend_pc_nxt_s      = redirect_pc;
                        ctrl_s.flush_id_ex = 1'b1;
                        flush_inc_s        = 1'b1;
                    end else begin
                        pend_pc_nxt_s = pend_pc_r;
                    end
                    if (!if_busy) begin
                        pc_load_s   = 1'b1;
                        pc_target_s = redirect_req ? redirect_pc : pend_pc_r;
                        state_nxt_s = S_RUN;
                    end else begin
                        state_nxt_s = S_PEND;
                    end
                end
                S_RUN: begin
                    if (redirect_req) begin
                        // Redirect beats load_use: the dependent op is squashed.
                        ctrl_s.flush_if_id = 1'b1;
                        ctrl_s.flush_id_ex = 1'b1;
                        flush_inc_s        = 1'b1;
                        if (!if_busy) begin
                            pc_load_s   = 1'b1;
                            pc_target_s = redirect_pc;
                        end else begin
                            pend_pc_nxt_s = redirect_pc;
                            state_nxt_s   = S_PEND;
                        end
                    end else if (load_use) begin
                        ctrl_s.stall_if    = 1'b1;
                        ctrl_s.stall_id    = 1'b1;
                        ctrl_s.flush_id_ex = 1'b1;
                    end else if (if_busy) begin
                        ctrl_s.stall_if    = 1'b1;
                        ctrl_s.flush_if_id = 1'b1;
                    end else begin
                        ctrl_s = STAGE_CTRL_IDLE;
                    end
                end
                default: begin
                    state_nxt_s = S_RUN;
                end
            endcase
        end
    end

    assign stall_if      = ctrl_s.stall_if;
    assign stall_id      = ctrl_s.stall_id;
    assign stall_ex      = ctrl_s.stall_ex;
    assign stall_mem     = ctrl_s.stall_mem;
    assign flush_if_id   = ctrl_s.flush_if_id;
    assign flush_id_ex   = ctrl_s.flush_id_ex;
    assign flush_ex_mem  = ctrl_s.flush_ex_mem;
    assign pc_load       = pc_load_s;
    assign pc_target     = pc_target_s;
    assign redir_pending = (state_r == S_PEND);

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ctrl_s.stall_if),
        .clr   (cnt_clear),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc_s),
        .clr   (cnt_clear),
        .count (flush_cnt)
    );

endmodule
